// File: rtl/sd_spi_pkg.sv
// Shared definitions for the SD-card SPI master: register map, CTRL bit
// layout, FSM encoding and the CTRL readback packer.
package sd_spi_pkg;

  // Word offsets on the single address bit
  localparam logic REG_DATA = 1'b0;
  localparam logic REG_CTRL = 1'b1;

  // CTRL/STATUS bit positions
  localparam int CTRL_CS      = 0;
  localparam int CTRL_BUSY    = 1;
  localparam int CTRL_DONE    = 2;
  localparam int CTRL_WP      = 3;
  localparam int CTRL_DIV_LSB = 8;

  // Transfer FSM: IDLE, then alternating SCK-low / SCK-high phases
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  // Assemble the CTRL/STATUS word; unused bits read as zero
  function automatic logic [31:0] pack_ctrl(input logic [7:0] div,
                                            input logic       wp,
                                            input logic       done,
                                            input logic       busy,
                                            input logic       cs);
    logic [31:0] w;
    w                         = '0;
    w[CTRL_CS]                = cs;
    w[CTRL_BUSY]              = busy;
    w[CTRL_DONE]              = done;
    w[CTRL_WP]                = wp;
    w[CTRL_DIV_LSB +: 8]      = div;
    return w;
  endfunction

endpackage

// File: rtl/sd_spi_tick.sv
// Reloadable 8-bit down-counter that marks the last cycle of each SCK phase.
// A phase lasts i_div+1 cycles; o_tick is high during the final one.
module sd_spi_tick (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic       i_run,
  input  logic [7:0] i_div,
  output logic       o_tick
);

  logic [7:0] r_count;

  assign o_tick = i_run && (r_count == 8'd0);

  // Reload at transfer start and at every phase end, otherwise count down
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 8'd0;
    end else if (i_load || o_tick) begin
      r_count <= i_div;
    end else if (i_run) begin
      r_count <= r_count - 8'd1;
    end
  end

endmodule

// File: rtl/sd_spi.sv
// Bus-slave SPI (mode 0) master for the SD socket. The CPU writes a byte to
// DATA, the engine shifts it out MSB first while shifting MISO in, and the
// CPU polls CTRL.busy/done and reads the received byte back from DATA.
module sd_spi
  import sd_spi_pkg::*;
#(
  parameter logic [7:0] DEFAULT_DIV = 8'd62
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read,
  input  logic        write,
  input  logic        address,
  input  logic [31:0] writedata,
  input  logic [3:0]  be,
  output logic [31:0] readdata,
  output logic        sd_clk,
  output logic        sd_mosi,
  input  logic        sd_miso,
  output logic        sd_cs_n,
  input  logic        sd_wp_n
);

  state_t      r_state;
  state_t      w_state_next;
  logic        w_start;
  logic        w_rise;
  logic        w_fall;
  logic        w_finish;
  logic        w_tick;
  logic        w_running;
  logic        w_ctrl_wr;
  logic        w_data_rd;
  logic [31:0] w_rd_mux;

  logic        r_cs;
  logic        r_busy;
  logic        r_done;
  logic        r_sd_clk;
  logic        r_sd_mosi;
  logic [7:0]  r_div;
  logic [7:0]  r_tx;
  logic [7:0]  r_shift;
  logic [7:0]  r_rxbyte;
  logic [2:0]  r_bitcnt;
  logic        r_wp_meta;
  logic        r_wp;
  logic [31:0] r_readdata;

  // Bits of the bus that no register uses
  logic        w_unused;
  assign w_unused = &{1'b0, writedata[31:16], be[3:2]};

  // A DATA write starts a transfer only when the engine is already idle
  assign w_start   = write && (address == REG_DATA) && be[0] && !r_busy;
  assign w_ctrl_wr = write && (address == REG_CTRL);
  assign w_data_rd = read  && (address == REG_DATA);
  assign w_running = (r_state != ST_IDLE);

  sd_spi_tick u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_start),
    .i_run  (w_running),
    .i_div  (r_div),
    .o_tick (w_tick)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next state and the phase-change strobes that drive the datapath
  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    w_rise       = 1'b0;
    w_fall       = 1'b0;
    w_finish     = 1'b0;
    unique case (r_state)
      ST_IDLE: if (w_start) w_state_next = ST_LOW;
      ST_LOW: begin
        if (w_tick) begin
          w_rise       = 1'b1;
          w_state_next = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (w_tick) begin
          if (r_bitcnt == 3'd7) begin
            w_finish     = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_fall       = 1'b1;
            w_state_next = ST_LOW;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Software-visible control: chip select any time, divider only while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs  <= 1'b0;
      r_div <= DEFAULT_DIV;
    end else begin
      if (w_ctrl_wr && be[0])           r_cs  <= writedata[CTRL_CS];
      if (w_ctrl_wr && be[1] && !r_busy) r_div <= writedata[CTRL_DIV_LSB +: 8];
    end
  end

  // Shift engine: load on start, sample on SCK rise, shift out on SCK fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sd_clk  <= 1'b0;
      r_sd_mosi <= 1'b1;
      r_tx      <= 8'h00;
      r_shift   <= 8'h00;
      r_rxbyte  <= 8'h00;
      r_bitcnt  <= 3'd0;
    end else begin
      if (w_start) begin
        r_busy    <= 1'b1;
        r_done    <= 1'b0;
        r_tx      <= writedata[7:0];
        r_sd_mosi <= writedata[7];
        r_bitcnt  <= 3'd0;
      end
      if (w_rise) begin
        r_sd_clk <= 1'b1;
        r_shift  <= {r_shift[6:0], sd_miso};
      end
      if (w_fall) begin
        r_sd_clk  <= 1'b0;
        r_sd_mosi <= r_tx[6];
        r_tx      <= {r_tx[6:0], 1'b0};
        r_bitcnt  <= r_bitcnt + 3'd1;
      end
      if (w_finish) begin
        r_sd_clk  <= 1'b0;
        r_sd_mosi <= 1'b1;
        r_rxbyte  <= r_shift;
        r_busy    <= 1'b0;
        r_done    <= 1'b1;
        r_bitcnt  <= 3'd0;
      end
      // A DATA read wins over a done set in the same cycle
      if (w_data_rd) r_done <= 1'b0;
    end
  end

  // Two-flop synchroniser for the write-protect switch (active-low pin)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp_meta <= 1'b0;
      r_wp      <= 1'b0;
    end else begin
      r_wp_meta <= ~sd_wp_n;
      r_wp      <= r_wp_meta;
    end
  end

  // Read mux; a DATA read on the completion cycle sees the new byte
  always_comb begin
    w_rd_mux = '0;
    if (address == REG_DATA) w_rd_mux[7:0] = w_finish ? r_shift : r_rxbyte;
    else                     w_rd_mux      = pack_ctrl(r_div, r_wp, r_done, r_busy, r_cs);
  end

  // Registered read data, held until the next read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_readdata <= '0;
    else if (read) r_readdata <= w_rd_mux;
  end

  assign readdata = r_readdata;
  assign sd_clk   = r_sd_clk;
  assign sd_mosi  = r_sd_mosi;
  assign sd_cs_n  = ~r_cs;

endmodule

// File: tb/tb_sd_spi.sv
// Directed bench for sd_spi: MOSI bits and received bytes go through
// scoreboard queues filled when a transfer is launched.
module tb_sd_spi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic        address = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  be = '0;
  logic [31:0] readdata;
  logic        sd_clk;
  logic        sd_mosi;
  logic        sd_miso = 1'b0;
  logic        sd_cs_n;
  logic        sd_wp_n = 1'b1;

  int total = 0;
  int bad   = 0;

  logic       exp_bits[$];
  logic [7:0] exp_rx[$];

  int rises;
  int per_min;
  int per_max;

  sd_spi #(.DEFAULT_DIV(8'd62)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .read      (read),
    .write     (write),
    .address   (address),
    .writedata (writedata),
    .be        (be),
    .readdata  (readdata),
    .sd_clk    (sd_clk),
    .sd_mosi   (sd_mosi),
    .sd_miso   (sd_miso),
    .sd_cs_n   (sd_cs_n),
    .sd_wp_n   (sd_wp_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic a, input logic [31:0] d, input logic [3:0] b);
    address   = a;
    writedata = d;
    be        = b;
    write     = 1'b1;
    tick();
    write     = 1'b0;
    be        = 4'h0;
  endtask

  task automatic bus_read(input logic a, output logic [31:0] d);
    address = a;
    read    = 1'b1;
    tick();
    read    = 1'b0;
    d       = readdata;
  endtask

  task automatic check_data_read(input string tag);
    logic [31:0] d;
    logic [7:0]  e;
    bus_read(1'b0, d);
    e = exp_rx.pop_front();
    check(tag, d, {24'h0, e});
  endtask

  // Launch a transfer, drive MISO per bit, check each MOSI bit at SCK rise,
  // measure SCK half-periods, and poll CTRL until busy drops. One optional
  // bus access (read or write) is injected at cycle inj_cyc.
  task automatic xfer(input logic [7:0] tx, input logic [7:0] miso_pat,
                      input int inj_cyc, input logic inj_is_read,
                      input logic inj_addr, input logic [31:0] inj_data,
                      input logic [3:0] inj_be,
                      output int cycles, output logic [7:0] inj_rd);
    int   cyc;
    int   last;
    logic prev;
    logic b;
    for (int i = 7; i >= 0; i--) exp_bits.push_back(tx[i]);
    exp_rx.push_back(miso_pat);
    rises   = 0;
    per_min = 1 << 30;
    per_max = 0;
    cycles  = -1;
    inj_rd  = 8'h00;
    sd_miso = miso_pat[7];
    bus_write(1'b0, {24'h0, tx}, 4'b0001);
    cyc     = 1;
    last    = 1;
    prev    = 1'b0;
    address = 1'b1;
    read    = 1'b1;
    while (cycles < 0 && cyc < 4000) begin
      if (cyc == inj_cyc) begin
        address   = inj_addr;
        read      = inj_is_read;
        write     = !inj_is_read;
        writedata = inj_data;
        be        = inj_be;
      end
      tick();
      cyc++;
      if (cyc == inj_cyc + 1) begin
        if (inj_is_read) inj_rd = readdata[7:0];
        write   = 1'b0;
        be      = 4'h0;
        read    = 1'b1;
        address = 1'b1;
      end
      if (sd_clk !== prev) begin
        if (cyc - last < per_min) per_min = cyc - last;
        if (cyc - last > per_max) per_max = cyc - last;
        last = cyc;
        if (sd_clk === 1'b1) begin
          rises++;
          check("mosi_expected", 32'(exp_bits.size() != 0), 32'd1);
          if (exp_bits.size() != 0) begin
            b = exp_bits.pop_front();
            check("mosi_bit", {31'h0, sd_mosi}, {31'h0, b});
          end
          if (rises < 8) sd_miso = miso_pat[7 - rises];
        end
        prev = sd_clk;
      end
      if (cyc != inj_cyc + 1 && readdata[1] === 1'b0) cycles = cyc;
    end
    read = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  r;
    int          n;
    int          edges;
    logic        p;

    // Reset values
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_cs_n", {31'h0, sd_cs_n}, 32'd1);
    check("rst_sck",  {31'h0, sd_clk},  32'd0);
    check("rst_mosi", {31'h0, sd_mosi}, 32'd1);
    check("rst_readdata", readdata, 32'h0);
    bus_read(1'b1, d);
    check("rst_ctrl", d, 32'h0000_3E00);

    // Byte-enable gating of CTRL
    bus_write(1'b1, 32'h0000_0701, 4'b0001);
    check("be0_cs_n", {31'h0, sd_cs_n}, 32'd0);
    bus_read(1'b1, d);
    check("be0_ctrl", d, 32'h0000_3E01);
    bus_write(1'b1, 32'h0000_0000, 4'b0001);
    bus_write(1'b1, 32'h0000_0701, 4'b0010);
    bus_read(1'b1, d);
    check("be1_ctrl", d, 32'h0000_0700);

    // div=0, cs=1: 0xA5 out, 0x3C in; busy seen low on the poll one cycle
    // after the 16*(0+1)+1 transfer because readdata is registered
    bus_write(1'b1, 32'h0000_0001, 4'b0011);
    xfer(8'hA5, 8'h3C, -10, 1'b0, 1'b0, 32'h0, 4'h0, n, r);
    check("div0_cycles", 32'(n), 32'(16 * 1 + 1 + 1));
    check("div0_rises", 32'(rises), 32'd8);
    check("div0_status_done", readdata, 32'h0000_0005);
    check_data_read("div0_rx");
    bus_read(1'b1, d);
    check("div0_done_cleared", d, 32'h0000_0001);

    // DATA read landing on the completion edge returns the new byte
    sd_miso = 1'b1;
    exp_rx.push_back(8'hFF);
    bus_write(1'b0, 32'h0000_005A, 4'b0001);
    repeat (15) tick();
    check_data_read("same_cycle_rx");
    bus_read(1'b1, d);
    check("same_cycle_done", d, 32'h0000_0001);

    // Read during busy returns the previous byte
    xfer(8'h81, 8'h7E, 5, 1'b1, 1'b0, 32'h0, 4'h0, n, r);
    check("busy_read_prev", {24'h0, r}, 32'h0000_00FF);
    check("busy_read_cycles", 32'(n), 32'd18);
    check_data_read("busy_read_rx");

    // DATA write while busy is dropped
    xfer(8'h12, 8'h00, 6, 1'b0, 1'b0, 32'h0000_0034, 4'b0001, n, r);
    check("wr_busy_cycles", 32'(n), 32'd18);
    check("wr_busy_queue", 32'(exp_bits.size()), 32'd0);
    check_data_read("wr_busy_rx");

    // Default divider, with a div write while busy that must be ignored
    bus_write(1'b1, 32'h0000_3E01, 4'b0011);
    xfer(8'hFF, 8'hA0, 200, 1'b0, 1'b1, 32'h0000_0501, 4'b0010, n, r);
    check("dflt_cycles", 32'(n), 32'(16 * 63 + 1 + 1));
    check("dflt_per_min", 32'(per_min), 32'd63);
    check("dflt_per_max", 32'(per_max), 32'd63);
    check("dflt_rises", 32'(rises), 32'd8);
    bus_read(1'b1, d);
    check("dflt_div_kept", d, 32'h0000_3E05);
    check_data_read("dflt_rx");

    // Write-protect through the synchroniser
    sd_wp_n = 1'b0;
    repeat (2) tick();
    bus_read(1'b1, d);
    check("wp_set", {31'h0, d[3]}, 32'd1);
    sd_wp_n = 1'b1;
    repeat (3) tick();

    // Reset in the middle of a transfer
    bus_write(1'b0, 32'h0000_0055, 4'b0001);
    repeat (100) tick();
    rst_n = 1'b0;
    #1;
    check("abort_cs_n", {31'h0, sd_cs_n}, 32'd1);
    check("abort_sck",  {31'h0, sd_clk},  32'd0);
    check("abort_mosi", {31'h0, sd_mosi}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    bus_read(1'b1, d);
    check("abort_ctrl", d, 32'h0000_3E00);
    bus_read(1'b0, d);
    check("abort_rx", d, 32'h0);
    edges = 0;
    p     = sd_clk;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (sd_clk !== p) edges++;
      p = sd_clk;
    end
    check("abort_no_sck", 32'(edges), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
